// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mc_ctrl
// Brief    : Multi-cycle RV32I control unit (fetch/decode/exec/mem/wb) with
//            memory wait handshake, memory timeout and illegal-opcode trap.
//            Optional macro RV_M_EXT_EN enables M-extension MDWAIT stalls.
// Revision : 1.0
// ============================================================================
module riscv_mc_ctrl #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int TIMEOUT_W     = 8,
    parameter int STRICT_DECODE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        md_done,
    input  logic        trap_ack,
    output logic        cy1,
    output logic        cy2,
    output logic        walu,
    output logic        wmdr,
    output logic        wpc,
    output logic        wreg,
    output logic        ce,
    output logic        rw,
    output logic [1:0]  bw,
    output logic        rst_md,
    output logic [2:0]  fmt,
    output logic        trap,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MDWAIT = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [2:0] c_fmt_r = 3'd0;
    localparam logic [2:0] c_fmt_i = 3'd1;
    localparam logic [2:0] c_fmt_s = 3'd2;
    localparam logic [2:0] c_fmt_b = 3'd3;
    localparam logic [2:0] c_fmt_u = 3'd4;
    localparam logic [2:0] c_fmt_j = 3'd5;

    // Execution class decides the path taken after EXEC.
    localparam logic [2:0] c_cls_alu   = 3'd0;
    localparam logic [2:0] c_cls_load  = 3'd1;
    localparam logic [2:0] c_cls_store = 3'd2;
    localparam logic [2:0] c_cls_pc    = 3'd3;
    localparam logic [2:0] c_cls_md    = 3'd4;

    localparam logic [TIMEOUT_W-1:0] c_wait_last =
        TIMEOUT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [2:0]           r_state;
    logic [31:0]          r_ir;
    logic [TIMEOUT_W-1:0] r_wait;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal_op;
    logic       w_legal_fn;
    logic       w_legal;
    logic [2:0] w_fmt;
    logic [2:0] w_cls;
    logic       w_timeout;
    logic       w_rd_nz;
    logic       w_unused_ir;

    assign w_opcode    = r_ir[6:0];
    assign w_f3        = r_ir[14:12];
    assign w_f7        = r_ir[31:25];
    assign w_rd_nz     = (r_ir[11:7] != 5'd0);
    assign w_unused_ir = ^r_ir[24:15];

    always_comb begin
        w_legal_op = 1'b1;
        w_legal_fn = 1'b1;
        w_fmt      = c_fmt_i;
        w_cls      = c_cls_pc;
        case (w_opcode)
            c_op_lui, c_op_auipc: begin w_fmt = c_fmt_u; w_cls = c_cls_alu; end
            c_op_jal:    begin w_fmt = c_fmt_j; w_cls = c_cls_alu; end
            c_op_jalr:   begin w_cls = c_cls_alu; w_legal_fn = (w_f3 == 3'd0); end
            c_op_branch: begin
                w_fmt      = c_fmt_b;
                w_legal_fn = (w_f3 != 3'd2) && (w_f3 != 3'd3);
            end
            c_op_load: begin
                w_cls      = c_cls_load;
                w_legal_fn = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
            end
            c_op_store: begin
                w_fmt      = c_fmt_s;
                w_cls      = c_cls_store;
                w_legal_fn = (w_f3 <= 3'd2);
            end
            c_op_opimm: begin
                w_cls = c_cls_alu;
                if (w_f3 == 3'd1)
                    w_legal_fn = (w_f7 == 7'h00);
                else if (w_f3 == 3'd5)
                    w_legal_fn = (w_f7 == 7'h00) || (w_f7 == 7'h20);
            end
            c_op_op: begin
                w_fmt      = c_fmt_r;
                w_cls      = c_cls_alu;
                w_legal_fn = (w_f7 == 7'h00) ||
                             ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)));
`ifdef RV_M_EXT_EN
                if (w_f7 == 7'h01) begin
                    w_legal_fn = 1'b1;
                    w_cls      = c_cls_md;
                end
`endif
            end
            c_op_fence, c_op_system: w_legal_fn = (w_f3 == 3'd0);
            default: w_legal_op = 1'b0;
        endcase
    end

    assign w_legal   = w_legal_op && ((STRICT_DECODE == 0) || w_legal_fn);
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == c_wait_last);

    // The wait counter only survives consecutive not-ready cycles in FETCH/MEM,
    // so it is zero on entry to every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
            r_wait  <= '0;
        end else begin
            r_wait <= '0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= instr;
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    case (w_cls)
                        c_cls_load, c_cls_store: r_state <= S_MEM;
                        c_cls_alu:               r_state <= S_WB;
`ifdef RV_M_EXT_EN
                        c_cls_md:                r_state <= S_MDWAIT;
`else
                        c_cls_md:                r_state <= S_TRAP;
`endif
                        default:                 r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        r_state <= (w_cls == c_cls_load) ? S_WB : S_FETCH;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                    else
                        r_wait <= r_wait + 1'b1;
                end
                S_WB:     r_state <= S_FETCH;
                S_MDWAIT: if (md_done) r_state <= S_WB;
                S_TRAP:   if (trap_ack) r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        cy1    = 1'b0;
        cy2    = 1'b0;
        walu   = 1'b0;
        wmdr   = 1'b0;
        wpc    = 1'b0;
        wreg   = 1'b0;
        ce     = 1'b0;
        rw     = 1'b0;
        bw     = 2'b00;
        rst_md = 1'b0;
        trap   = 1'b0;
        fmt    = w_fmt;
        state  = r_state;
        case (r_state)
            S_FETCH: begin
                cy1 = 1'b1;
                ce  = 1'b1;
                rw  = 1'b1;
                bw  = 2'b10;
            end
            S_DECODE: cy2 = 1'b1;
            S_EXEC: begin
                walu = 1'b1;
                wpc  = (w_cls == c_cls_pc);
`ifdef RV_M_EXT_EN
                rst_md = (w_cls == c_cls_md);
`endif
            end
            S_MEM: begin
                ce   = 1'b1;
                rw   = (w_cls == c_cls_load);
                wmdr = (w_cls == c_cls_load);
                bw   = w_f3[1:0];
                wpc  = (w_cls == c_cls_store) && mem_ready;
            end
            S_WB: begin
                wpc  = 1'b1;
                wreg = w_rd_nz;
            end
            S_TRAP: begin
                trap = 1'b1;
                wpc  = trap_ack;
            end
            default: ;
        endcase
        if (!rst_n) begin
            cy1    = 1'b0;
            cy2    = 1'b0;
            walu   = 1'b0;
            wmdr   = 1'b0;
            wpc    = 1'b0;
            wreg   = 1'b0;
            ce     = 1'b0;
            rw     = 1'b0;
            bw     = 2'b00;
            rst_md = 1'b0;
            trap   = 1'b0;
            fmt    = 3'd0;
            state  = 3'd0;
        end
    end

endmodule
`default_nettype wire
